mul_iter: RTL and testbench
===========================

Name: mul_iter

Overview:
- Iterative radix-2 shift-add multiplier for the CPU M-extension datapath.
- Computes 2N-bit products one bit per cycle and returns the low or high N bits per RISC-V op encoding.
- Uses the same start/done handshake style as the iterative divider, so the execute stage drives both units through one sequencer.

Parameters:
- N, 32, operand and result width; product width is 2N.
- CW, 6, width of the iteration counter; must satisfy 2^CW > N.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low N), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high).
- a  input  N  multiplicand, rs1; sampled with start.
- b  input  N  multiplier, rs2; sampled with start.
- flush  input  1  synchronous abort from pipeline kill.
- busy  output  1  high from accept until done, inclusive.
- result  output  N  selected product half; held until next accept.
- done  output  1  one-cycle pulse, result valid.

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, result=0, counter=0, internal product and operand registers=0.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - On start=1 and flush=0, register op, |a| and |b|, plus neg = sign(a)^sign(b) for the signed ops. Go to CALC with counter=0 and busy=1.
  - a is signed for MULH/MULHSU. b is signed for MULH only. MUL and MULHU treat both operands as unsigned; the low half is identical for all op types.
  - start=0: stay in IDLE; done=0; result holds.
- CALC:
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper N+1 bits of the 2N-bit accumulator.
  - Then shift the {carry, accumulator} pair right by 1, shift the multiplier right by 1, and increment the counter.
  - Exit to SIGN after exactly N CALC cycles (counter reaches N-1 and updates).
- SIGN:
  - If neg=1, product = two's complement of the 2N-bit product; otherwise unchanged.
  - Select low N bits for MUL, high N bits otherwise. Go to DONE.
- DONE: result <= selected half, done=1 for this cycle only, busy=1. Next state IDLE; busy=0 from the following cycle.
- Latency: accept edge at cycle 0; done high during cycle N+2 (34 for N=32). Back-to-back: a start held high in the cycle after done is accepted; minimum issue interval is N+3 cycles.
- start while busy: ignored, no queueing. Operands and op are frozen after accept.
- flush:
  - Highest priority after rst. In any non-IDLE state, go to IDLE next edge with busy=0 and no done pulse; result keeps its previous value.
  - flush together with start in IDLE: start is rejected.
  - flush during the DONE cycle: the done pulse still occurs (already committed), then IDLE.
- rst mid-operation: immediate return to the reset values; no done.
- Width rules:
  - Negating 0x8000_0000 yields 0x8000_0000, treated as unsigned 2^31, which is correct.
  - All additions are N+1 bits wide; no overflow is possible in 2N bits.
- Zero operands are not special-cased; they take full latency.

Test Plan:
- MUL a=7, b=6 -> done after 34 cycles, result=0x0000_002A; busy high for exactly 35 cycles.
- MULHU a=b=0xFFFF_FFFF -> result=0xFFFF_FFFE; repeat with op=MUL -> result=0x0000_0001.
- MULH a=0x8000_0000, b=0xFFFF_FFFF -> result=0x0000_0000; op=MUL gives 0x8000_0000. MULH a=b=0xFFFF_FFFF -> result=0x0000_0000.
- MULHSU a=0xFFFF_FFFF (−1), b=0x0000_0002 -> result=0xFFFF_FFFF; MULH a=−3, b=5 -> 0xFFFF_FFFF, MUL -> 0xFFFF_FFF1.
- Handshake, part 1: start pulsed again at cycle 10 with different operands -> ignored, first result unaffected.
- Handshake, part 2: flush at cycle 20 -> no done, busy low at cycle 21, result unchanged. A new start at cycle 22 completes normally.
- Handshake, part 3: rst asserted mid-CALC -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/mul_iter_if.sv
// Start/done handshake bundle between the execute-stage sequencer and the
// iterative multiplier.
interface mul_iter_if #(
   parameter int N = 32
);
   // Handshake: the sequencer raises start with op/a/b while busy is low and
   // flush is low. The unit accepts on that edge; busy stays high from the
   // accept cycle through the done cycle. done is a single-cycle pulse during
   // which result is valid. result then holds until the next accept. flush
   // aborts any in-flight operation without a done pulse.
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         flush;
   logic         busy;
   logic [N-1:0] result;
   logic         done;

   modport master (
      output start, op, a, b, flush,
      input  busy, result, done
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, result, done
   );
endinterface

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: sign-magnitude operands, N add/shift cycles,
// one sign-fixup cycle, then a single-cycle done pulse with the selected half.
module mul_iter #(
   parameter int N  = 32,
   parameter int CW = 6
) (
   input  logic       clk,
   input  logic       rst,
   mul_iter_if.slave  bus,
   output logic [1:0] state_dbg
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [N-1:0]   mcand;
   logic [N-1:0]   mplier;
   logic [2*N-1:0] acc;
   logic [CW-1:0]  cnt;
   logic [1:0]     op_q;
   logic           neg;
   logic [N-1:0]   result_q;

   logic           accept;
   logic           last_iter;
   logic           a_signed;
   logic           b_signed;
   logic [N-1:0]   a_abs;
   logic [N-1:0]   b_abs;
   logic [N:0]     sum;
   logic [2*N-1:0] prod;
   logic [N-1:0]   half;

   assign accept    = (state == IDLE) && bus.start && !bus.flush;
   assign last_iter = (cnt == CW'(N - 1));

   always_comb begin
      a_signed = (bus.op == 2'b01) || (bus.op == 2'b10);
      b_signed = (bus.op == 2'b01);
      // Negating the most negative value wraps to itself, which read as
      // unsigned is exactly its magnitude.
      a_abs = (a_signed && bus.a[N-1]) ? -bus.a : bus.a;
      b_abs = (b_signed && bus.b[N-1]) ? -bus.b : bus.b;
      sum   = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
      prod  = neg ? -acc : acc;
      half  = (op_q == 2'b00) ? prod[N-1:0] : prod[2*N-1:N];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = CALC;
         CALC: begin
            if (bus.flush)      state_nx = IDLE;
            else if (last_iter) state_nx = SIGN;
         end
         SIGN: state_nx = bus.flush ? IDLE : DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         op_q     <= '0;
         neg      <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q   <= bus.op;
                  mcand  <= a_abs;
                  mplier <= b_abs;
                  neg    <= (a_signed & bus.a[N-1]) ^ (b_signed & bus.b[N-1]);
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            CALC: begin
               // The carry out of the add lands in the top bit after the shift.
               acc    <= mplier[0] ? {sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
            end
            SIGN: begin
               // Loaded here so result is already valid while done is high.
               if (!bus.flush) result_q <= half;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE) || accept;
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign state_dbg  = state;
endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: issue tasks push expected results, a monitor
// pops and compares on every done pulse.
module tb_mul_iter;
   localparam int N = 32;
   localparam logic [1:0] MUL    = 2'b00;
   localparam logic [1:0] MULH   = 2'b01;
   localparam logic [1:0] MULHSU = 2'b10;
   localparam logic [1:0] MULHU  = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_dbg;

   mul_iter_if #(.N(N)) bus ();

   mul_iter #(.N(N), .CW(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   logic [N-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   logic [N-1:0] last_res;

   typedef struct {
      logic [1:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] r;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: got result %h, expected no done", bus.result);
         end else begin
            logic [N-1:0] e;
            e = exp_q.pop_front();
            if (bus.result !== e) begin
               n_err++;
               $display("FAIL result: got %h, expected %h", bus.result, e);
            end
         end
      end
   end

   // Cycle 0 is the cycle start is presented (accept at its closing edge).
   task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] expv, input int poke_at, input int flush_at,
                         output int busy_cnt, output int done_at);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (flush_at < 0) exp_q.push_back(expv);
      busy_cnt = 0;
      done_at  = -1;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_at = c;
            break;
         end
         if (flush_at >= 0 && c == flush_at + 1) begin
            check("flush_busy", N'(bus.busy), N'(0));
            check("flush_result_held", bus.result, last_res);
            break;
         end
         if (c == poke_at) begin
            bus.start = 1'b1;
            bus.op    = MUL;
            bus.a     = 32'h0000_0055;
            bus.b     = 32'h0000_0003;
         end
         if (c == flush_at) bus.flush = 1'b1;
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         bus.flush = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      int bc;
      int da;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      last_res  = '0;

      vecs.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vecs.push_back('{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
      vecs.push_back('{MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
      vecs.push_back('{MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF});
      vecs.push_back('{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
      vecs.push_back('{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF});
      vecs.push_back('{MULH,   32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF});
      vecs.push_back('{MUL,    32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1});
      vecs.push_back('{MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002});
      vecs.push_back('{MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF});
      vecs.push_back('{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{MUL,    32'h0000_0000, 32'h0000_1234, 32'h0000_0000});

      repeat (2) @(negedge clk);
      check("reset_busy",   N'(bus.busy),  N'(0));
      check("reset_done",   N'(bus.done),  N'(0));
      check("reset_result", bus.result,    N'(0));
      check("reset_state",  N'(state_dbg), N'(0));
      rst = 1'b0;

      // Basic latency and busy window.
      run_op(MUL, 32'd7, 32'd6, 32'h0000_002A, -1, -1, bc, da);
      check("mul7x6_latency", N'(da), N'(34));
      check("mul7x6_busy_cycles", N'(bc), N'(35));
      last_res = 32'h0000_002A;

      // Directed vectors issued back-to-back.
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, -1, -1, bc, da);
         check("vec_latency", N'(da), N'(34));
         last_res = vecs[i].r;
      end

      // A second start mid-operation is ignored.
      run_op(MUL, 32'h0000_0100, 32'h0000_0003, 32'h0000_0300, 10, -1, bc, da);
      check("poke_latency", N'(da), N'(34));
      last_res = 32'h0000_0300;

      // Flush at cycle 20, then a fresh start at cycle 22.
      run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, -1, 20, bc, da);
      run_op(MULH, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, -1, -1, bc, da);
      check("after_flush_latency", N'(da), N'(34));
      last_res = 32'hFFFF_FFFF;

      // start together with flush in IDLE is rejected.
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.op    = MUL;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      #1;
      check("start_flush_busy",  N'(bus.busy),  N'(0));
      check("start_flush_state", N'(state_dbg), N'(0));

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = MUL;
      bus.a     = 32'd7;
      bus.b     = 32'd6;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_busy",   N'(bus.busy),  N'(0));
      check("async_rst_done",   N'(bus.done),  N'(0));
      check("async_rst_result", bus.result,    N'(0));
      check("async_rst_state",  N'(state_dbg), N'(0));
      @(negedge clk);
      rst = 1'b0;
      last_res = '0;

      run_op(MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, -1, -1, bc, da);
      check("post_rst_latency", N'(da), N'(34));

      repeat (5) @(negedge clk);
      check("queue_drained", N'(exp_q.size()), N'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
